// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, types and address helpers for the icache tag path
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 3;
  localparam int TAG_W  = 23;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL_WR
  } state_e;

  typedef struct packed {
    logic             v1;
    logic [TAG_W-1:0] tag1;
    logic             v0;
    logic [TAG_W-1:0] tag0;
  } tag_entry_t;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/icache_tag_cmp.sv
// rtl/icache_tag_cmp.sv - 2-way tag compare with hit-way and victim selection
module icache_tag_cmp
  import icache_pkg::*;
(
  input  tag_entry_t       entry,
  input  logic [TAG_W-1:0] tag,
  input  logic             lru_way,
  output logic             hit,
  output logic             hit_way,
  output logic             victim
);

  logic hit0;
  logic hit1;

  assign hit0 = entry.v0 && (entry.tag0 == tag);
  assign hit1 = entry.v1 && (entry.tag1 == tag);
  assign hit  = hit0 | hit1;

  // way0 wins when both ways match
  assign hit_way = ~hit0;

  // fill invalid ways first, way0 preferred, before falling back to LRU
  assign victim = !entry.v0 ? 1'b0 :
                  !entry.v1 ? 1'b1 : lru_way;

endmodule

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - icache tag lookup/refill controller driving the tag SRAM port
// Optional perf counters enabled by ICACHE_TAG_PERF_EN.
module icache_tag_ctrl
  import icache_pkg::*;
(
  input  logic              clk0,
  input  logic              rst_aL,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_way,
  output logic [IDX_W-1:0]  resp_idx,
  output logic              refill_req_valid,
  input  logic              refill_req_ready,
  output logic [ADDR_W-1:0] refill_req_addr,
  input  logic              refill_done,
  output logic              tag_csb0,
  output logic              tag_web0,
  output logic [1:0]        tag_wmask0,
  output logic [IDX_W-1:0]  tag_addr0,
  output logic [47:0]       tag_din0,
  input  logic [47:0]       tag_dout0
`ifdef ICACHE_TAG_PERF_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic             victim_q;
  logic [SETS-1:0]  lru_q;

  tag_entry_t rd_entry;
  logic       cmp_hit;
  logic       cmp_way;
  logic       cmp_victim;
  logic       unused_offset;

  assign rd_entry      = tag_entry_t'(tag_dout0);
  assign unused_offset = ^req_addr[OFF_W-1:0];

  icache_tag_cmp u_cmp (
    .entry   (rd_entry),
    .tag     (tag_q),
    .lru_way (lru_q[idx_q]),
    .hit     (cmp_hit),
    .hit_way (cmp_way),
    .victim  (cmp_victim)
  );

  always_ff @(posedge clk0 or negedge rst_aL) begin
    if (!rst_aL) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    tag_csb0   = 1'b1;
    tag_web0   = 1'b1;
    tag_wmask0 = 2'b00;
    tag_addr0  = idx_q;
    tag_din0   = '0;
    case (state_q)
      ST_IDLE: begin
        // SRAM read is launched on the same edge that accepts the request
        req_ready = 1'b1;
        tag_csb0  = !req_valid;
        tag_addr0 = addr_idx(req_addr);
        if (req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP:    state_d = cmp_hit ? ST_IDLE : ST_MISS_REQ;
      ST_MISS_REQ:  if (refill_req_ready) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (refill_done) state_d = ST_FILL_WR;
      ST_FILL_WR: begin
        tag_csb0   = 1'b0;
        tag_web0   = 1'b0;
        tag_wmask0 = victim_q ? 2'b10 : 2'b01;
        tag_din0   = {1'b1, tag_q, 1'b1, tag_q};
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_aL) begin
    if (!rst_aL) begin
      tag_q            <= '0;
      idx_q            <= '0;
      victim_q         <= 1'b0;
      lru_q            <= '0;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_way         <= 1'b0;
      resp_idx         <= '0;
      refill_req_valid <= 1'b0;
      refill_req_addr  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            tag_q <= addr_tag(req_addr);
            idx_q <= addr_idx(req_addr);
          end
        end
        ST_LOOKUP: begin
          if (cmp_hit) begin
            resp_valid   <= 1'b1;
            resp_hit     <= 1'b1;
            resp_way     <= cmp_way;
            resp_idx     <= idx_q;
            lru_q[idx_q] <= ~cmp_way;
          end else begin
            victim_q         <= cmp_victim;
            refill_req_valid <= 1'b1;
            refill_req_addr  <= {tag_q, idx_q, {OFF_W{1'b0}}};
          end
        end
        ST_MISS_REQ: begin
          if (refill_req_ready) refill_req_valid <= 1'b0;
        end
        ST_FILL_WR: begin
          resp_valid   <= 1'b1;
          resp_hit     <= 1'b0;
          resp_way     <= victim_q;
          resp_idx     <= idx_q;
          lru_q[idx_q] <= ~victim_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_TAG_PERF_EN
  always_ff @(posedge clk0 or negedge rst_aL) begin
    if (!rst_aL) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (cmp_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else         perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_tag_ctrl.md
# icache_tag_ctrl

Lookup and refill controller for the 64-set, 2-way instruction-cache tag array (48-bit entries, 24 bits per way). Sits directly upstream of the tag SRAM and drives its single RW port. Consumes the SRAM read data to resolve hit/way, and on a miss issues a line refill request, picks a victim via per-set LRU, and writes the new tag. Fetch-side requests enter here; the data-array controller consumes the hit/way response.

## Interface
- ADDR_W, 32, fetch address width
- IDX_W, 6, set index bits (addr[8:3])
- OFF_W, 3, line offset bits (8-byte line)
- TAG_W, 23, tag bits (addr[31:9]); TAG_W+IDX_W+OFF_W == ADDR_W

- clk0  in  1  clock
- rst_aL  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch lookup request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  fetch address
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  1 = hit; 0 = miss serviced (tag now installed)
- resp_way  out  1  hit way or filled victim way
- resp_idx  out  IDX_W  set index of the response
- refill_req_valid  out  1  line refill request
- refill_req_ready  in  1  refill accepted
- refill_req_addr  out  ADDR_W  {tag, idx, OFF_W'b0}
- refill_done  in  1  one-cycle pulse: line data written
- tag_csb0, tag_web0  out  1 each  SRAM chip select / write enable, active low
- tag_wmask0  out  2  bit0 = way0 [23:0], bit1 = way1 [47:24]
- tag_addr0  out  IDX_W  SRAM address
- tag_din0  out  48  {v1, tag1, v0, tag0}
- tag_dout0  in  48  SRAM read data, same layout
- perf_hit_cnt, perf_miss_cnt  out  32 each  only with ICACHE_TAG_PERF_EN

## Operation
- FSM: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL_WR.
- IDLE: req_ready=1; tag_csb0 = !req_valid, tag_web0=1, tag_addr0=req_addr[8:3] (combinational). On accept, register tag/idx -> LOOKUP.
- LOOKUP: hit0 = dout[23] & dout[22:0]==tag; hit1 = dout[47] & dout[46:24]==tag. Both set -> way0 wins. Hit: register resp (hit=1), lru[idx] <= ~way -> IDLE. Miss: victim = first invalid way (way0 preferred), else lru[idx]; register victim, refill_req_valid<=1 -> MISS_REQ.
- MISS_REQ: hold refill_req_valid/addr stable until refill_req_ready at posedge -> MISS_WAIT (valid drops).
- MISS_WAIT: wait refill_done -> FILL_WR. refill_done in any other state ignored.
- FILL_WR: tag_csb0=0, tag_web0=0, tag_wmask0 = one-hot victim, tag_din0 = {1,tag,1,tag}; lru[idx] <= ~victim; resp (hit=0, way=victim) -> IDLE.
- LRU: 64 flops, lru[i] = way to replace next.
- Outside IDLE/FILL_WR: tag_csb0=1, tag_web0=1, wmask 0, din 0.

## Timing
- Request accepted at edge N; SRAM captures same edge, dout valid after negedge N; hit resp_valid high for cycle N+1; req_ready high N+1; next accept edge N+2.
- Miss: refill_req_valid rises cycle N+1; response coincides with cycle after FILL_WR edge; SRAM writes at following negedge, so a read accepted next edge sees new tag.
- Reset (async, any state): state IDLE, req_ready=1 after release, resp_valid/resp_hit/resp_way/resp_idx=0, refill_req_valid=0, refill_req_addr=0, lru all 0, counters 0; SRAM strobes inactive (csb0=1, web0=1, wmask0=0). Outstanding refill is abandoned; stale refill_done ignored.

## Configuration
- ICACHE_TAG_PERF_EN defined: perf_hit_cnt increments on each hit response, perf_miss_cnt on each LOOKUP miss; 32-bit wrap-around, async-cleared.
- Undefined: ports and counters absent.

## Structure
- Shared package icache_pkg: TAG_W/IDX_W/OFF_W constants, FSM state enum, tag-entry struct {v1,tag1,v0,tag0}, address-field extract functions.
- One sub-module: icache_tag_cmp (combinational 2-way compare, hit/way/victim select).

## Test plan
- Cold miss 0x0000_1008 (idx 1, tag 0x8) -> refill_req_addr 0x0000_1008; after refill_done, write wmask 01, din {1,0x8,1,0x8}; resp hit=0 way=0.
- Repeat 0x0000_1008 -> resp_valid exactly one cycle after accept, hit=1 way=0, no SRAM write.
- 0x0000_1208 (idx 1, tag 0x9) -> miss, victim way1 (invalid), wmask 10.
- 0x0000_1408 (tag 0xA), both ways valid, lru[1]=0 -> victim way0; then 0x1208 hits way1.
- refill_req_ready held low 5 cycles -> refill_req_valid/addr stable; rst_aL low in MISS_WAIT -> IDLE, all outputs zero, later refill_done ignored.
- With ICACHE_TAG_PERF_EN: above sequence -> perf_hit_cnt=2, perf_miss_cnt=3.
